// File: rtl/bsg_alu_accum.sv
// ---------------------------------------------------------------------------
// bsg_alu_accum
//
// Command-side initiator for an external 4-op combinational ALU (bsg_alu).
// It accepts one packet of operand beats on a valid/ready interface and
// loads the first beat into the accumulator. Every later beat drives the ALU
// with (accumulator, operand, op), and the ALU result is folded back into the
// accumulator. After the last beat the final value is held on a valid/yumi
// output until the consumer takes it.
//
// Optional feature: define BSG_ALU_ACCUM_COUNT_EN to add count_o, a
// saturating count of the beats accepted in the current or held packet.
//
// Parameters:
//   width_p        operand / accumulator / ALU data width (>= 1)
//   count_width_p  beat counter width (only used with BSG_ALU_ACCUM_COUNT_EN)
//
// Ports:
//   clk_i          clock
//   reset_i        asynchronous active-high reset
//   v_i            operand beat valid
//   op_i           ALU op for this beat: 00 AND, 01 XOR, 10 NAND, 11 ADD
//   operand_i      operand data
//   last_i         beat is the last of its packet
//   ready_o        block accepts a beat this cycle
//   alu_control_o  ALU control, passes op_i straight through
//   alu_a_o        ALU a operand, the accumulator register
//   alu_b_o        ALU b operand, passes operand_i straight through
//   alu_res_i      ALU result, returned combinationally in the same cycle
//   v_o            final result valid
//   data_o         final result (the accumulator)
//   count_o        beats in the packet, saturating (optional)
//   yumi_i         consumer takes the result; only meaningful while v_o=1
// ---------------------------------------------------------------------------
module bsg_alu_accum #(
  parameter int width_p       = 8,
  parameter int count_width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [1:0]         op_i,
  input  logic [width_p-1:0] operand_i,
  input  logic               last_i,
  output logic               ready_o,
  output logic [1:0]         alu_control_o,
  output logic [width_p-1:0] alu_a_o,
  output logic [width_p-1:0] alu_b_o,
  input  logic [width_p-1:0] alu_res_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
`ifdef BSG_ALU_ACCUM_COUNT_EN
  output logic [count_width_p-1:0] count_o,
`endif
  input  logic               yumi_i
);

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_ACCUM = 2'd1;
  localparam logic [1:0] STATE_DONE  = 2'd2;

  logic [1:0]         state_r, state_n;
  logic [width_p-1:0] acc_r, acc_n;
  logic               accept;

  // The ALU sits outside this block; we only route operands to it. Its
  // outputs are meaningful only during an accepted ACCUM beat.
  assign alu_control_o = op_i;
  assign alu_a_o       = acc_r;
  assign alu_b_o       = operand_i;

  // Input is open in IDLE and ACCUM. DONE closes it so a pending result
  // cannot be overwritten before the consumer has taken it.
  assign ready_o = (state_r == STATE_IDLE) || (state_r == STATE_ACCUM);
  assign v_o     = (state_r == STATE_DONE);
  assign data_o  = acc_r;
  assign accept  = v_i & ready_o;

  // Next-state and accumulator update. The first beat of a packet loads the
  // operand directly (its op is meaningless). Later beats take the external
  // ALU result. yumi leaves DONE with no bypass, so a new packet can start
  // no earlier than the following cycle.
  always_comb begin
    state_n = state_r;
    acc_n   = acc_r;
    case (state_r)
      STATE_IDLE: begin
        if (accept) begin
          acc_n   = operand_i;
          state_n = last_i ? STATE_DONE : STATE_ACCUM;
        end
      end
      STATE_ACCUM: begin
        if (accept) begin
          acc_n   = alu_res_i;
          state_n = last_i ? STATE_DONE : STATE_ACCUM;
        end
      end
      STATE_DONE: begin
        if (yumi_i) begin
          state_n = STATE_IDLE;
        end
      end
      default: begin
        state_n = STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= STATE_IDLE;
      acc_r   <= '0;
    end else begin
      state_r <= state_n;
      acc_r   <= acc_n;
    end
  end

`ifdef BSG_ALU_ACCUM_COUNT_EN
  localparam logic [count_width_p-1:0] count_max_lp = '1;

  logic [count_width_p-1:0] count_r;

  // The first beat restarts the count at 1. Later beats increment up to the
  // counter's ceiling and then stick there. The count clears when the result
  // is taken, so it always describes the current or held packet.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_r <= '0;
    end else if (accept) begin
      if (state_r == STATE_IDLE) begin
        count_r <= count_width_p'(1);
      end else if (count_r != count_max_lp) begin
        count_r <= count_r + count_width_p'(1);
      end
    end else if (v_o && yumi_i) begin
      count_r <= '0;
    end
  end

  assign count_o = count_r;
`else
  // Without the counter, count_width_p has no effect on the logic. It is
  // still referenced here so that an illegal value appears as a named scope
  // in the elaborated hierarchy.
  if (count_width_p < 1) begin : g_count_width_invalid
  end
`endif

endmodule
